mcast_local_ejector: RTL and testbench
======================================

Name: mcast_local_ejector

Overview:
- Tile-side receiver on a router's Local output port; the ejection end of the mesh multicast/unicast flit protocol.
- Decodes each arriving flit header and delivers only flits addressed to this tile into a small FIFO for the tile core.
- Drops multicast replicas that arrive with Local clear or that duplicate an already-delivered tag.
- Exposes saturating delivery/drop counters for bring-up and test.

Parameters:
- FLIT_W, 64, flit width in bits (minimum 32).
- FIFO_DEPTH, 4, delivery FIFO entries (power of two, ≥2).
- HIST_DEPTH, 4, number of recent multicast tags kept for duplicate suppression (≥1).
- MY_ROW, 0, this tile's mesh row (8-bit compare).
- MY_COL, 0, this tile's mesh column (8-bit compare).
- CNT_W, 16, counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_flit  in  FLIT_W  flit from router Local output.
- in_valid  in  1  in_flit valid.
- in_ready  out  1  ejector can consume a flit this cycle.
- out_flit  out  FLIT_W  flit to tile core (FIFO head).
- out_valid  out  1  out_flit valid.
- out_ready  in  1  core accepts out_flit.
- hist_clear  in  1  one-cycle pulse; invalidates all tag history entries.
- cnt_delivered  out  CNT_W  flits pushed to FIFO.
- cnt_dup  out  CNT_W  multicast flits dropped as duplicates.
- cnt_stray  out  CNT_W  flits dropped as not-for-this-tile.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Header fields:
  - mcast flag = flit[31].
  - mask = flit[30:26], ordered N=bit30, E=bit29, S=bit28, W=bit27, L=bit26.
  - tag = flit[23:16].
  - dest_row = flit[15:8]; dest_col = flit[7:0].
  - All other bits are payload and pass through unmodified.
- Handshake:
  - in_ready = !fifo_full, combinational from FIFO state only. It does not depend on in_valid or on decode.
  - Accept occurs when in_valid && in_ready.
  - A dropped flit is still consumed; the router sees it accepted.
- Classification of an accepted flit, priority order:
  1. Unicast (flag=0): deliver if dest_row==MY_ROW && dest_col==MY_COL; else stray.
  2. Multicast with L=0: stray, regardless of dest.
  3. Multicast with L=1 and tag matching a valid history entry: dup.
  4. Multicast with L=1, no match: deliver. Write the tag into history at the round-robin write pointer, set that entry valid, and advance the pointer modulo HIST_DEPTH. The oldest entry is overwritten on wrap.
- Unicast flits never read or write history. Multicast destination fields are ignored; only L decides.
- Delivery:
  - A delivered flit is written to the FIFO on the accept edge.
  - Latency is one cycle: out_valid is high the cycle after accept if the FIFO was empty.
  - FIFO order is strict FIFO.
- FIFO push/pop:
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leaves the level unchanged.
  - When full, in_ready=0, so no push occurs; a pop in that cycle raises in_ready the next cycle, with no combinational ready-through.
  - out_flit holds stable while out_valid && !out_ready.
- Counters:
  - Each increments by 1 on its classification event and saturates at all-ones (no wrap).
  - At most one counter increments per cycle.
- hist_clear:
  - Clears all valid bits and the write pointer next edge.
  - If coincident with an accept, the accepted flit's classification uses the pre-clear history, and its tag write (if any) is discarded.
- Reset:
  - When rst=1 at a clock edge: FIFO empty, out_valid=0, out_flit=0, fifo_level=0, in_ready=1 the following cycle, all counters=0, history invalid, pointer=0.
  - Reset mid-transfer discards FIFO contents without popping.
  - While rst is high, in_ready=0.

Test Plan:
- MY_ROW=1, MY_COL=0; unicast dest (1,0) payload 0xA5 → out_valid next cycle, out_flit identical, cnt_delivered=1. Then unicast dest (0,1) → no output, cnt_stray=1.
- Multicast mask=5'b01101, tag=0x12, accepted → delivered once. Same flit again → dropped, cnt_dup=1, cnt_delivered unchanged.
- Multicast mask=5'b01100 (L clear) → dropped, cnt_stray increments, history unchanged. A later L=1 flit with the same tag is delivered.
- HIST_DEPTH=4: deliver tags 1,2,3,4,5, then tag 1 → delivered (evicted). Then tag 5 → dup. Then hist_clear pulse, then tag 5 → delivered.
- out_ready=0, push 4 unicast flits → fifo_level=4, in_ready=0, a 5th flit is held by the source. Raise out_ready for one cycle → one pop, in_ready=1 next cycle, order preserved.
- Assert rst with 3 flits queued → out_valid=0, fifo_level=0, counters 0 next cycle. A previously seen tag is delivered after reset.

Source files
------------

// File: rtl/mcast_local_ejector.sv
// Local-port ejector for the mesh multicast/unicast flit protocol.
// Decodes each accepted flit, drops strays and duplicate multicast
// replicas, and queues flits for this tile in a small FIFO.
module mcast_local_ejector #(
  parameter int FLIT_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int HIST_DEPTH = 4,
  parameter int MY_ROW     = 0,
  parameter int MY_COL     = 0,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLIT_W-1:0]             in_flit,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FLIT_W-1:0]             out_flit,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          hist_clear,
  output logic [CNT_W-1:0]              cnt_delivered,
  output logic [CNT_W-1:0]              cnt_dup,
  output logic [CNT_W-1:0]              cnt_stray,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HLAST    = HW'(HIST_DEPTH - 1);
  localparam logic [7:0]    ROW8     = 8'(MY_ROW);
  localparam logic [7:0]    COL8     = 8'(MY_COL);

  typedef struct packed {
    logic       mc;
    logic [4:0] mask;   // N E S W L
    logic [7:0] tag;
    logic [7:0] row;
    logic [7:0] col;
  } hdr_t;

  hdr_t hdr;
  assign hdr = '{mc: in_flit[31], mask: in_flit[30:26], tag: in_flit[23:16],
                 row: in_flit[15:8], col: in_flit[7:0]};

  // FIFO storage and state
  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  // multicast tag history
  logic [7:0]        hist_tag [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [HW-1:0]     hptr;

  logic accept, hit, deliver, dup, stray, pop;

  assign in_ready   = !rst && (count != FULL_LVL);
  assign out_valid  = (count != '0);
  assign out_flit   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  // tag lookup against valid history entries
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++)
      if (hist_vld[i] && hist_tag[i] == hdr.tag) hit = 1'b1;
  end

  // classification: unicast by address, multicast by L bit then history
  always_comb begin
    deliver = 1'b0;
    dup     = 1'b0;
    if (accept) begin
      if (!hdr.mc)          deliver = (hdr.row == ROW8) && (hdr.col == COL8);
      else if (hdr.mask[0]) begin
        dup     = hit;
        deliver = !hit;
      end
    end
    stray = accept && !deliver && !dup;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (deliver) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({deliver, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO data write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (deliver) mem[wr_ptr] <= in_flit;
  end

  // history: clear wins over a coincident tag write
  always_ff @(posedge clk) begin
    if (rst || hist_clear) begin
      hist_vld <= '0;
      hptr     <= '0;
    end else if (deliver && hdr.mc) begin
      hist_vld[hptr] <= 1'b1;
      hptr           <= (hptr == HLAST) ? '0 : hptr + HW'(1);
    end
  end

  // tag payload of history entries
  always_ff @(posedge clk) begin
    if (!rst && !hist_clear && deliver && hdr.mc) hist_tag[hptr] <= hdr.tag;
  end

  // saturating bring-up counters; classes are mutually exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_delivered <= '0;
      cnt_dup       <= '0;
      cnt_stray     <= '0;
    end else begin
      if (deliver && cnt_delivered != '1) cnt_delivered <= cnt_delivered + 1'b1;
      if (dup     && cnt_dup       != '1) cnt_dup       <= cnt_dup + 1'b1;
      if (stray   && cnt_stray     != '1) cnt_stray     <= cnt_stray + 1'b1;
    end
  end

endmodule

// File: tb/tb_mcast_local_ejector.sv
// Directed bench for mcast_local_ejector (tile at row 1, col 0).
module tb_mcast_local_ejector;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_flit;
  logic        in_valid, in_ready;
  logic [63:0] out_flit;
  logic        out_valid, out_ready, hist_clear;
  logic [15:0] cnt_delivered, cnt_dup, cnt_stray;
  logic [2:0]  fifo_level;

  int n_chk = 0, n_fail = 0;
  int e_del = 0, e_dup = 0, e_str = 0;

  mcast_local_ejector #(.FLIT_W(64), .FIFO_DEPTH(4), .HIST_DEPTH(4),
                        .MY_ROW(1), .MY_COL(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .hist_clear(hist_clear),
    .cnt_delivered(cnt_delivered), .cnt_dup(cnt_dup), .cnt_stray(cnt_stray),
    .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] uc(input logic [7:0] r, input logic [7:0] c,
                                     input logic [31:0] pl);
    return {pl, 1'b0, 5'b0, 2'b0, 8'h00, r, c};
  endfunction

  function automatic logic [63:0] mc(input logic [4:0] m, input logic [7:0] t,
                                     input logic [31:0] pl);
    return {pl, 1'b1, m, 2'b0, t, 16'h0000};
  endfunction

  // present a flit until it is accepted, then sample #1 after that edge
  task automatic send(input logic [63:0] f, input logic clr);
    int  n = 0;
    logic acc;
    in_flit = f; in_valid = 1'b1; hist_clear = clr;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0; hist_clear = 1'b0;
    if (!acc) chk("send_timeout", 64'(n), 64'(0));
  endtask

  // send with out_ready=1 and check classification via counters/output
  // cls: 0 deliver, 1 dup, 2 stray
  task automatic send_chk(input string tag, input logic [63:0] f, input int cls,
                          input logic clr = 1'b0);
    send(f, clr);
    if (cls == 0) e_del++; else if (cls == 1) e_dup++; else e_str++;
    chk({tag, "_ovld"}, 64'(out_valid), 64'(cls == 0));
    if (cls == 0) chk({tag, "_oflit"}, out_flit, f);
    chk({tag, "_cdel"}, 64'(cnt_delivered), 64'(e_del));
    chk({tag, "_cdup"}, 64'(cnt_dup), 64'(e_dup));
    chk({tag, "_cstr"}, 64'(cnt_stray), 64'(e_str));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b1; hist_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_flit", out_flit, 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_cnts", {cnt_delivered, cnt_dup, cnt_stray}, 64'(0));
    rst = 1'b0; #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // unicast hit and miss
    send_chk("uc_hit",  uc(8'd1, 8'd0, 32'hA5), 0);
    send_chk("uc_miss", uc(8'd0, 8'd1, 32'h5A), 2);

    // multicast delivery, duplicate, L clear
    send_chk("mc_first", mc(5'b01101, 8'h12, 32'h1), 0);
    send_chk("mc_dup",   mc(5'b01101, 8'h12, 32'h2), 1);
    send_chk("mc_lclr",  mc(5'b01100, 8'h34, 32'h3), 2);
    send_chk("mc_after_lclr", mc(5'b00001, 8'h34, 32'h4), 0);
    // multicast ignores destination fields, unicast never touches history
    send_chk("uc_same_tag", {32'h9, 1'b0, 5'b0, 2'b0, 8'h12, 8'd1, 8'd0}, 0);

    // history eviction with depth 4
    send(64'(0), 1'b1);             // stray flit while clearing
    e_str++;
    for (int t = 1; t <= 5; t++) send_chk("hist_fill", mc(5'b00001, 8'(t), 32'(t)), 0);
    send_chk("hist_evicted", mc(5'b00001, 8'd1, 32'h10), 0);
    send_chk("hist_dup5",    mc(5'b00001, 8'd5, 32'h11), 1);
    send(uc(8'd3, 8'd3, 32'h0), 1'b1); // clear pulse alongside a stray
    e_str++;
    send_chk("hist_clr_5",   mc(5'b00001, 8'd5, 32'h12), 0);
    // clear coincident with accept: old history decides, write discarded
    send_chk("clr_coin_dup", mc(5'b00001, 8'd5, 32'h13), 1, 1'b1);
    send_chk("clr_coin_5",   mc(5'b00001, 8'd5, 32'h14), 0);
    send_chk("clr_coin_wr",  mc(5'b00001, 8'd9, 32'h15), 0, 1'b1);
    send_chk("clr_coin_9",   mc(5'b00001, 8'd9, 32'h16), 0);

    // back-pressure: fill FIFO
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_empty", 64'(fifo_level), 64'(0));
    for (int k = 1; k <= 4; k++) send(uc(8'd1, 8'd0, 32'(k)), 1'b0);
    e_del += 4;
    chk("bp_level4", 64'(fifo_level), 64'(4));
    chk("bp_in_ready0", 64'(in_ready), 64'(0));
    in_flit = uc(8'd1, 8'd0, 32'd5); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_held_cnt", 64'(cnt_delivered), 64'(e_del));
    chk("bp_head", out_flit, uc(8'd1, 8'd0, 32'd1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_pop_level", 64'(fifo_level), 64'(3));
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; e_del++;
    chk("bp_level_refill", 64'(fifo_level), 64'(4));
    chk("bp_cdel", 64'(cnt_delivered), 64'(e_del));
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("bp_order", out_flit, uc(8'd1, 8'd0, 32'(k)));
      @(posedge clk); #1;
    end
    chk("bp_drained", 64'(out_valid), 64'(0));

    // reset with queued flits
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(uc(8'd1, 8'd0, 32'(k + 8)), 1'b0);
    chk("rq_level3", 64'(fifo_level), 64'(3));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rq_out_valid", 64'(out_valid), 64'(0));
    chk("rq_level", 64'(fifo_level), 64'(0));
    chk("rq_cnts", {cnt_delivered, cnt_dup, cnt_stray}, 64'(0));
    chk("rq_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0; out_ready = 1'b1;
    e_del = 0; e_dup = 0; e_str = 0;
    #1;
    send_chk("rq_tag_again", mc(5'b00001, 8'd9, 32'h77), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
